// File: rtl/div_module.sv
// div_module: iterative restoring divider, one quotient bit per clock.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready operand handshake (mode, op1 dividend, op2 divisor)
//   out_valid/out_ready result handshake (quotient, remainder, div_by_zero)
//
// Optional feature macro: DIV_SIGNED_EN
//   defined   -> mode selects signed division (magnitude conversion, sign
//                fix-up and the most-negative / -1 overflow path)
//   undefined -> mode is ignored, all divisions are unsigned
//
// Latency from the acceptance edge T: out_valid after edge T+WIDTH for a
// normal division, after edge T+1 for divide-by-zero and signed overflow.
module div_module #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             mode,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder
  logic [WIDTH-1:0] dvd_q, dvd_d;     // dividend shifting out, quotient bits shifting in
  logic [WIDTH-1:0] dvs_q, dvs_d;     // divisor magnitude
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             sp_q, sp_d;       // special case: result pre-loaded in dvd/rem
  logic             zdiv_q, zdiv_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rmd_q, rmd_d;
  logic             dbz_q, dbz_d;

  logic             take;
  logic [WIDTH:0]   rem_sh, trial;
  logic [WIDTH-1:0] q_next, r_next, q_fix, r_fix;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic             ovf_in;

  assign take = in_valid && (state_q == S_IDLE);

  // One restoring step: shift {rem, dividend} left and trial-subtract.
  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign trial  = rem_sh - {1'b0, dvs_q};
  assign q_next = {dvd_q[WIDTH-2:0], ~trial[WIDTH]};
  assign r_next = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];

`ifdef DIV_SIGNED_EN
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic neg_q_in, neg_r_in;
  logic negq_q, negq_d, negr_q, negr_d;

  always_comb begin
    neg_r_in = mode & op1[WIDTH-1];
    neg_q_in = mode & (op1[WIDTH-1] ^ op2[WIDTH-1]);
    // Negating the most-negative value yields the same bits, which is
    // already its correct unsigned magnitude.
    a_mag    = neg_r_in ? -op1 : op1;
    b_mag    = (mode & op2[WIDTH-1]) ? -op2 : op2;
    ovf_in   = mode & (op1 == MOST_NEG) & (op2 == '1);
    negq_d   = take ? neg_q_in : negq_q;
    negr_d   = take ? neg_r_in : negr_q;
    q_fix    = negq_q ? -q_next : q_next;
    r_fix    = negr_q ? -r_next : r_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = mode;
  assign a_mag  = op1;
  assign b_mag  = op2;
  assign ovf_in = 1'b0;
  assign q_fix  = q_next;
  assign r_fix  = r_next;
`endif

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sp_d    = sp_q;
    zdiv_d  = zdiv_q;
    quo_d   = quo_q;
    rmd_d   = rmd_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      S_IDLE: begin
        if (take) begin
          state_d = S_BUSY;
          // Special cases spend a single BUSY cycle with their result parked
          // in dvd/rem so they share the normal completion path.
          if (op2 == '0) begin
            sp_d   = 1'b1;
            zdiv_d = 1'b1;
            dvd_d  = '1;
            rem_d  = op1;
            cnt_d  = CNT_ONE;
          end else if (ovf_in) begin
            sp_d   = 1'b1;
            zdiv_d = 1'b0;
            dvd_d  = op1;
            rem_d  = '0;
            cnt_d  = CNT_ONE;
          end else begin
            sp_d   = 1'b0;
            zdiv_d = 1'b0;
            dvd_d  = a_mag;
            dvs_d  = b_mag;
            rem_d  = '0;
            cnt_d  = CNT_FULL;
          end
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (!sp_q) begin
          rem_d = r_next;
          dvd_d = q_next;
        end
        if (cnt_q == CNT_ONE) begin
          state_d = S_DONE;
          if (sp_q) begin
            quo_d = dvd_q;
            rmd_d = rem_q;
            dbz_d = zdiv_q;
          end else begin
            quo_d = q_fix;
            rmd_d = r_fix;
            dbz_d = 1'b0;
          end
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sp_q    <= 1'b0;
      zdiv_q  <= 1'b0;
      quo_q   <= '0;
      rmd_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sp_q    <= sp_d;
      zdiv_q  <= zdiv_d;
      quo_q   <= quo_d;
      rmd_q   <= rmd_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign quotient    = quo_q;
  assign remainder   = rmd_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_module.sv
// Directed and scoreboard-driven checks for div_module (WIDTH = 32).
module tb_div_module;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, mode;
  logic [W-1:0] op1, op2;
  logic         out_valid, out_ready;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
  } exp_t;

  exp_t sb[$];

  div_module #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .mode(mode),
    .op1(op1), .op2(op2),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one operand pair (DUT assumed idle), then wait for out_valid
  // with out_ready low; lat = edges after the acceptance edge.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic m, output int lat);
    op1 = a; op2 = b; mode = m; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    int   lat;
    int   seen;
    logic stable_ok;
    int   sent, received, cycles;
    exp_t e;
    logic [W-1:0] a, b;

    rst = 1'b0; in_valid = 1'b0; mode = 1'b0; op1 = '0; op2 = '0; out_ready = 1'b0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_dbz", div_by_zero, 0);
    rst = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 1);

    // Unsigned 100/7 with in_ready low while busy.
    op1 = 100; op2 = 7; mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("busy_in_ready", in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    check("u100_7_latency", 32'(lat), 32);
    check("u100_7_q", quotient, 14);
    check("u100_7_r", remainder, 2);
    check("u100_7_dbz", div_by_zero, 0);
    consume();
    check("u100_7_drop", out_valid, 0);
    check("u100_7_ready", in_ready, 1);

    // Reset mid-BUSY aborts and clears the previous result.
    op1 = 100; op2 = 7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    rst = 1'b0;
    #1;
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("midrst_ready_after", in_ready, 1);
    seen = 0;
    repeat (40) begin
      if (out_valid) seen++;
      tick();
    end
    check("midrst_no_result", 32'(seen), 0);

    // Divide by zero: raw op1 as remainder, one-cycle latency.
    do_div(32'h1234, 32'h0, 1'b0, lat);
    check("dz_latency", 32'(lat), 1);
    check("dz_q", quotient, 32'hFFFF_FFFF);
    check("dz_r", remainder, 32'h1234);
    check("dz_flag", div_by_zero, 1);
    consume();
    check("dz_drop", out_valid, 0);
    check("dz_ready", in_ready, 1);

    // Boundary operands.
    do_div(32'hFFFF_FFFF, 32'h1, 1'b0, lat);
    check("max_div1_q", quotient, 32'hFFFF_FFFF);
    check("max_div1_r", remainder, 0);
    consume();
    do_div(32'd5, 32'd7, 1'b0, lat);
    check("small_q", quotient, 0);
    check("small_r", remainder, 5);
    consume();
    do_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, lat);
    check("maxmax_q", quotient, 1);
    check("maxmax_r", remainder, 0);
    consume();

`ifdef DIV_SIGNED_EN
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
    check("s_m7_2_latency", 32'(lat), 32);
    check("s_m7_2_q", quotient, 32'hFFFF_FFFD);
    check("s_m7_2_r", remainder, 32'hFFFF_FFFF);
    consume();
    do_div(32'd7, 32'hFFFF_FFFE, 1'b1, lat);
    check("s_7_m2_q", quotient, 32'hFFFF_FFFD);
    check("s_7_m2_r", remainder, 1);
    consume();
    do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat);
    check("s_ovf_latency", 32'(lat), 1);
    check("s_ovf_q", quotient, 32'h8000_0000);
    check("s_ovf_r", remainder, 0);
    check("s_ovf_dbz", div_by_zero, 0);
    consume();
`else
    // mode is ignored: the operands divide as unsigned values.
    do_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat);
    check("nosign_q", quotient, 32'h7FFF_FFFC);
    check("nosign_r", remainder, 1);
    consume();
`endif

    // Backpressure: result held, in_valid pulses ignored.
    do_div(32'd1000, 32'd33, 1'b0, lat);
    stable_ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = i[0];
      op1 = 32'(i * 11);
      op2 = 32'd3;
      if (quotient !== 32'd30 || remainder !== 32'd10 || in_ready !== 1'b0 || out_valid !== 1'b1)
        stable_ok = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    check("bp_stable", stable_ok, 1);
    check("bp_q", quotient, 30);
    check("bp_r", remainder, 10);
    consume();
    check("bp_drop", out_valid, 0);
    check("bp_ready", in_ready, 1);
    tick();
    check("bp_no_extra", out_valid, 0);

    // Random back-to-back traffic against the scoreboard.
    sent = 0; received = 0; cycles = 0;
    mode = 1'b0;
    while ((sent < 100 || received < sent) && cycles < 20000) begin
      a = $urandom;
      b = ($urandom_range(0, 1) == 0) ? W'($urandom_range(1, 255)) : W'($urandom);
      if (b == '0) b = 1;
      op1 = a; op2 = b;
      in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      if (out_valid && out_ready) begin
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rand_q", quotient, e.q);
          check("rand_r", remainder, e.r);
        end
        received++;
      end
      if (in_valid && in_ready) begin
        e.q = a / b;
        e.r = a % b;
        sb.push_back(e);
        sent++;
      end
      tick();
      cycles++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("rand_sent", 32'(sent), 100);
    check("rand_received", 32'(received), 100);
    check("rand_sb_empty", 32'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_module.md
# div_module

Iterative restoring divider for the RISC-V execute stage, the multi-cycle counterpart to the single-cycle add/subtract unit. It accepts a dividend/divisor pair over a valid/ready handshake, computes one quotient bit per clock by trial subtraction, and returns quotient and remainder over a second valid/ready handshake. Divide-by-zero and signed-overflow results follow RISC-V M-extension semantics.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits (≥ 2)

Ports:
- clk  input  1  clock, rising-edge
- rst  input  1  reset, asynchronous, active-low
- in_valid  input  1  operand pair valid
- in_ready  output  1  divider can accept operands
- mode  input  1  0 = unsigned, 1 = signed (see Configuration); sampled with operands
- op1  input  WIDTH  dividend
- op2  input  WIDTH  divisor
- out_valid  output  1  quotient/remainder valid
- out_ready  input  1  consumer accepts result
- quotient  output  WIDTH  op1 / op2
- remainder  output  WIDTH  op1 % op2
- div_by_zero  output  1  set with result when op2 was 0

## Operation
- States: IDLE, BUSY, DONE. Reset (rst low, asynchronous) forces IDLE; in_ready=1 after reset release; out_valid=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- IDLE: in_ready=1. On in_valid && in_ready: latch op1, op2, mode; clear partial remainder; counter=WIDTH.
  - op2==0: go to DONE next edge; quotient=all ones, remainder=op1 (raw), div_by_zero=1.
  - Signed, op1=most-negative, op2=all ones: go to DONE next edge; quotient=op1, remainder=0, div_by_zero=0.
  - Otherwise go to BUSY.
- BUSY: in_ready=0. Each cycle: shift {rem, dividend} left 1; trial = rem − divisor (WIDTH+1 bits); if trial non-negative, rem=trial and quotient bit=1, else bit=0; counter decrements. When counter reaches 0 go to DONE.
- Signed mode: operands converted to magnitudes on acceptance; on completion quotient negated if signs of op1 and op2 differ, remainder negated if op1 negative (remainder takes dividend's sign).
- DONE: out_valid=1; quotient, remainder, div_by_zero held stable while out_valid && !out_ready. On out_ready go to IDLE; out_valid drops next edge.
- in_ready is 0 in BUSY and DONE; new operands are never accepted in the same cycle a result is consumed.
- in_valid/op changes while not in IDLE are ignored.
- out_ready while not in DONE is ignored.
- rst asserted mid-operation: operation aborted, all outputs to reset values immediately, no result produced.

## Timing
- Acceptance edge = T. Normal division: out_valid rises after edge T+WIDTH (WIDTH BUSY cycles); in_ready rises the cycle after the result handshake.
- Divide-by-zero and signed overflow: out_valid rises after edge T+1.
- Minimum initiation interval with out_ready tied high: WIDTH+2 cycles (normal), 3 cycles (special cases).
- Outputs registered; no combinational path from in_valid/op1/op2 to any output, or from out_ready to in_ready.

## Configuration
- DIV_SIGNED_EN defined: mode port honoured; signed magnitude conversion, sign fix-up and signed-overflow path compiled in.
- DIV_SIGNED_EN undefined: mode ignored, all divisions unsigned; sign logic and overflow path absent. Divide-by-zero behaviour unchanged.

## Test plan
- Reset: hold rst low mid-BUSY with op1=100, op2=7 -> outputs 0, in_ready=1 after release, no out_valid ever produced.
- Unsigned: op1=100, op2=7, mode=0, out_ready=1 -> out_valid exactly 32 cycles after acceptance, quotient=14, remainder=2, div_by_zero=0.
- Divide by zero: op1=0x1234, op2=0 -> out_valid after 1 cycle, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
- Signed (DIV_SIGNED_EN): op1=−7 (0xFFFFFFF9), op2=2, mode=1 -> quotient=−3 (0xFFFFFFFD), remainder=−1 (0xFFFFFFFF); op1=0x80000000, op2=0xFFFFFFFF -> quotient=0x80000000, remainder=0 after 1 cycle.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> quotient/remainder stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> out_valid drops, in_ready=1 next cycle.
- Back-to-back: 100 random unsigned pairs (nonzero divisor) with random in_valid/out_ready gaps -> every result matches op1/op2 and op1%op2, results in order, none dropped or duplicated.
